// File: rtl/ts_surface_mem.sv
// Timestamp surface: one word per DVS pixel, two read ports and one write port, zero-cleared after reset.
// Define TS_MEM_PARITY_EN to store an even-parity bit per entry and expose a sticky parity_err output.
module ts_surface_mem #(
  parameter int DVS_WIDTH       = 346,
  parameter int DVS_HEIGHT      = 260,
  parameter int WORD_SIZE       = 18,
  parameter int CAVIAR_X_Y_BITS = 9,
  parameter int READ_LATENCY    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cen,
  input  logic                       rw,
  input  logic [CAVIAR_X_Y_BITS-1:0] addr_port1_x,
  input  logic [CAVIAR_X_Y_BITS-1:0] addr_port1_y,
  input  logic [CAVIAR_X_Y_BITS-1:0] addr_port2_x,
  input  logic [CAVIAR_X_Y_BITS-1:0] addr_port2_y,
  input  logic [WORD_SIZE-1:0]       write_data_mem,
  output logic [WORD_SIZE-1:0]       read_data1_mem,
  output logic [WORD_SIZE-1:0]       read_data2_mem,
  output logic                       read_data_mem_vld1,
  output logic                       read_data_mem_vld2,
  output logic                       init_done,
`ifdef TS_MEM_PARITY_EN
  output logic                       parity_err,
`endif
  output logic                       oob_wr_err
);

  localparam int N     = DVS_WIDTH * DVS_HEIGHT;
  localparam int LIN_W = $clog2(N);
  localparam int HALF  = (N + 1) / 2;
  localparam int CW    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int ST    = READ_LATENCY - 1;
`ifdef TS_MEM_PARITY_EN
  localparam int MW    = WORD_SIZE + 1;
`else
  localparam int MW    = WORD_SIZE;
`endif

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        clr_cnt_reg;
  logic                 clr_we, wr_we, rd_req, wr_oob;
  logic                 in1, in2, clr_b_ok;
  logic [LIN_W-1:0]     lin1, lin2, clr_a, clr_b;
  logic [MW-1:0]        wr_word, ram_q1, ram_q2;
  logic [MW-1:0]        mem [0:N-1];
  logic [ST-1:0]        vld_pipe_reg, inr1_pipe_reg, inr2_pipe_reg;
  logic [WORD_SIZE-1:0] dat1_last, dat2_last;

  // Range check on the raw fields so an out-of-range x can never alias into the next row.
  assign in1  = (32'(addr_port1_x) < 32'(DVS_WIDTH)) && (32'(addr_port1_y) < 32'(DVS_HEIGHT));
  assign in2  = (32'(addr_port2_x) < 32'(DVS_WIDTH)) && (32'(addr_port2_y) < 32'(DVS_HEIGHT));
  assign lin1 = LIN_W'(addr_port1_y) * LIN_W'(DVS_WIDTH) + LIN_W'(addr_port1_x);
  assign lin2 = LIN_W'(addr_port2_y) * LIN_W'(DVS_WIDTH) + LIN_W'(addr_port2_x);

  assign clr_a    = LIN_W'({clr_cnt_reg, 1'b0});
  assign clr_b    = LIN_W'({clr_cnt_reg, 1'b1});
  assign clr_b_ok = 32'(clr_b) < 32'(N);
  assign wr_oob   = (state_reg == S_READY) && cen && rw && !in1;

`ifdef TS_MEM_PARITY_EN
  assign wr_word = {^write_data_mem, write_data_mem};
`else
  assign wr_word = write_data_mem;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_CLEAR;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    clr_we     = 1'b0;
    wr_we      = 1'b0;
    rd_req     = 1'b0;
    case (state_reg)
      S_CLEAR: begin
        clr_we = 1'b1;
        if (clr_cnt_reg == CW'(HALF - 1)) begin
          state_next = S_READY;
        end
      end
      S_READY: begin
        if (cen) begin
          wr_we  = rw && in1;
          rd_req = !rw;
        end
      end
      default: state_next = S_CLEAR;
    endcase
  end

  // Storage array: two write lanes for the clear sweep, registered reads on both ports.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_a] <= '0;
      if (clr_b_ok) begin
        mem[clr_b] <= '0;
      end
    end else if (wr_we) begin
      mem[lin1] <= wr_word;
    end
    if (rd_req && in1) begin
      ram_q1 <= mem[lin1];
    end
    if (rd_req && in2) begin
      ram_q2 <= mem[lin2];
    end
  end

  generate
    if (ST == 1) begin : g_no_dly
      assign dat1_last = ram_q1[WORD_SIZE-1:0];
      assign dat2_last = ram_q2[WORD_SIZE-1:0];
    end else begin : g_dly
      logic [WORD_SIZE-1:0] dly1_reg [1:ST-1];
      logic [WORD_SIZE-1:0] dly2_reg [1:ST-1];
      always_ff @(posedge clk) begin
        dly1_reg[1] <= ram_q1[WORD_SIZE-1:0];
        dly2_reg[1] <= ram_q2[WORD_SIZE-1:0];
        for (int i = 2; i < ST; i++) begin
          dly1_reg[i] <= dly1_reg[i-1];
          dly2_reg[i] <= dly2_reg[i-1];
        end
      end
      assign dat1_last = dly1_reg[ST-1];
      assign dat2_last = dly2_reg[ST-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt_reg        <= '0;
      init_done          <= 1'b0;
      oob_wr_err         <= 1'b0;
      vld_pipe_reg       <= '0;
      inr1_pipe_reg      <= '0;
      inr2_pipe_reg      <= '0;
      read_data1_mem     <= '0;
      read_data2_mem     <= '0;
      read_data_mem_vld1 <= 1'b0;
      read_data_mem_vld2 <= 1'b0;
`ifdef TS_MEM_PARITY_EN
      parity_err         <= 1'b0;
`endif
    end else begin
      if (state_reg == S_CLEAR) begin
        clr_cnt_reg <= clr_cnt_reg + CW'(1);
      end
      init_done <= (state_next == S_READY);
      if (wr_oob) begin
        oob_wr_err <= 1'b1;
      end
      // Bit 0 is the newest stage; the truncating cast drops the oldest.
      vld_pipe_reg       <= ST'({vld_pipe_reg, rd_req});
      inr1_pipe_reg      <= ST'({inr1_pipe_reg, in1});
      inr2_pipe_reg      <= ST'({inr2_pipe_reg, in2});
      read_data_mem_vld1 <= vld_pipe_reg[ST-1];
      read_data_mem_vld2 <= vld_pipe_reg[ST-1];
      if (vld_pipe_reg[ST-1]) begin
        read_data1_mem <= inr1_pipe_reg[ST-1] ? dat1_last : '0;
        read_data2_mem <= inr2_pipe_reg[ST-1] ? dat2_last : '0;
      end
`ifdef TS_MEM_PARITY_EN
      if (vld_pipe_reg[0] && ((inr1_pipe_reg[0] && ^ram_q1) || (inr2_pipe_reg[0] && ^ram_q2))) begin
        parity_err <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ts_surface_mem.sv
// Scoreboard bench for ts_surface_mem: reads push expected pairs, the output monitor pops and compares.
module tb_ts_surface_mem;
  localparam int W     = 346;
  localparam int H     = 260;
  localparam int SWEEP = 44980;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b0;
  logic        rw  = 1'b0;
  logic [8:0]  x1 = '0, y1 = '0, x2 = '0, y2 = '0;
  logic [17:0] wdata = '0;
  logic [17:0] rd1, rd2;
  logic        vld1, vld2, init_done, oob_wr_err;

  ts_surface_mem dut (
    .clk(clk), .rst(rst), .cen(cen), .rw(rw),
    .addr_port1_x(x1), .addr_port1_y(y1), .addr_port2_x(x2), .addr_port2_y(y2),
    .write_data_mem(wdata), .read_data1_mem(rd1), .read_data2_mem(rd2),
    .read_data_mem_vld1(vld1), .read_data_mem_vld2(vld2),
    .init_done(init_done), .oob_wr_err(oob_wr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [17:0] d1;
    logic [17:0] d2;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [17:0] model [int];
  bit          tb_ready = 0;
  int          checks = 0;
  int          failures = 0;
  int          vld_cnt = 0;
  logic [17:0] last1 = '0, last2 = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [17:0] peek(input int x, input int y);
    int lin;
    if (x >= W || y >= H) return '0;
    lin = y * W + x;
    return model.exists(lin) ? model[lin] : '0;
  endfunction

  task automatic drive(input bit c, input bit r, input int ax1, input int ay1,
                       input int ax2, input int ay2, input logic [17:0] d);
    exp_t e;
    @(posedge clk);
    #1;
    cen = c; rw = r; wdata = d;
    x1 = 9'(ax1); y1 = 9'(ay1); x2 = 9'(ax2); y2 = 9'(ay2);
    if (c && tb_ready) begin
      if (r) begin
        if (ax1 < W && ay1 < H) model[ay1 * W + ax1] = d;
        $display("cyc %0d WR (%0d,%0d) <= 0x%0h", cyc, ax1, ay1, d);
      end else begin
        e.due = cyc + 2;
        e.d1  = peek(ax1, ay1);
        e.d2  = peek(ax2, ay2);
        sb_q.push_back(e);
        last1 = e.d1;
        last2 = e.d2;
        $display("cyc %0d RD (%0d,%0d)/(%0d,%0d) exp 0x%0h/0x%0h", cyc, ax1, ay1, ax2, ay2, e.d1, e.d2);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, '0);
  endtask

  always @(negedge clk) begin
    if (vld1 || vld2) begin
      vld_cnt++;
      check("vld1", {31'b0, vld1}, 1);
      check("vld2", {31'b0, vld2}, 1);
      if (sb_q.size() == 0) begin
        check("vld_unexpected", {31'b0, vld1 | vld2}, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("vld_cycle", cyc, mon_e.due);
        check("rd1", {14'b0, rd1}, {14'b0, mon_e.d1});
        check("rd2", {14'b0, rd2}, {14'b0, mon_e.d2});
      end
    end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      check("vld_missing", {31'b0, vld1}, 1);
      void'(sb_q.pop_front());
    end
  end

  initial begin
    bit early;
    int cnt0;
    int ax, ay;

    repeat (3) @(posedge clk);
    #1;
    check("rst_init_done", {31'b0, init_done}, 0);
    check("rst_vld1", {31'b0, vld1}, 0);
    check("rst_vld2", {31'b0, vld2}, 0);
    check("rst_oob", {31'b0, oob_wr_err}, 0);
    check("rst_rd1", {14'b0, rd1}, 0);
    check("rst_rd2", {14'b0, rd2}, 0);
    rst = 1'b0;

    // Clear sweep: reads and an out-of-range write are issued but must be ignored.
    early = 0;
    for (int j = 1; j < SWEEP; j++) begin
      if (j <= 4) drive(1, 0, 5, 7, 345, 259, '0);
      else if (j == 6) drive(1, 1, 400, 3, 0, 0, 18'h3FFFF);
      else drive(0, 0, 0, 0, 0, 0, '0);
      early |= init_done;
    end
    check("init_early", {31'b0, early}, 0);
    check("oob_in_clear", {31'b0, oob_wr_err}, 0);
    drive(0, 0, 0, 0, 0, 0, '0);
    check("init_done", {31'b0, init_done}, 1);
    tb_ready = 1;

    drive(1, 0, 5, 7, 345, 259, '0);
    drive(1, 1, 10, 20, 0, 0, 18'h1ABCD);
    drive(1, 0, 10, 20, 10, 20, '0);
    drive(1, 0, 346, 0, 0, 260, '0);
    drive(1, 1, 400, 3, 0, 0, 18'h2AAAA);
    drive(0, 0, 0, 0, 0, 0, '0);
    check("oob_wr_err", {31'b0, oob_wr_err}, 1);
    drive(1, 0, 400, 3, 92, 4, '0);

    for (int i = 0; i < 6; i++) drive(1, 1, i % 4, i / 4, 0, 0, 18'($urandom));
    idle(4);
    cnt0 = vld_cnt;
    for (int i = 0; i < 25; i++) begin
      if (i == 12) idle(3);
      ax = $urandom_range(0, 3);
      ay = $urandom_range(0, 1);
      if (i % 3 == 0) drive(1, 0, ax, ay, ax, ay, '0);
      else if (i % 5 == 0) drive(1, 0, ax, ay, W + i, ay, '0);
      else drive(1, 0, ax, ay, $urandom_range(0, 3), $urandom_range(0, 1), '0);
    end
    idle(5);
    check("burst_cnt", vld_cnt - cnt0, 25);
    check("hold1", {14'b0, rd1}, {14'b0, last1});
    check("hold2", {14'b0, rd2}, {14'b0, last2});
    check("sb_drain", sb_q.size(), 0);

    // Reset with two reads in flight: neither may produce a vld.
    drive(1, 1, 50, 60, 0, 0, 18'h15555);
    idle(4);
    drive(1, 0, 50, 60, 50, 60, '0);
    drive(1, 0, 50, 60, 1, 1, '0);
    @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    model.delete();
    tb_ready = 0;
    idle(4);
    check("rst2_vld1", {31'b0, vld1}, 0);
    check("rst2_init", {31'b0, init_done}, 0);
    check("rst2_oob", {31'b0, oob_wr_err}, 0);
    check("rst2_rd1", {14'b0, rd1}, 0);
    rst = 1'b0;

    early = 0;
    for (int j = 1; j < SWEEP; j++) begin
      drive(0, 0, 0, 0, 0, 0, '0);
      early |= init_done;
    end
    check("init_early2", {31'b0, early}, 0);
    drive(0, 0, 0, 0, 0, 0, '0);
    check("init_done2", {31'b0, init_done}, 1);
    tb_ready = 1;
    drive(1, 0, 50, 60, 10, 20, '0);
    idle(4);
    check("sb_drain2", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ts_surface_mem.md
Name: ts_surface_mem

Overview:
- Memory-side responder for the MLP activation builder's timestamp-surface port. Holds one WORD_SIZE word per DVS pixel.
- Serves two independent read ports per cycle and one write per cycle through port 1, with fixed read latency and per-port valid strobes.
- Zero-clears the whole surface after reset, and zero-fills reads whose addresses fall outside the sensor array (neighbourhood patches at the edges).

Parameters:
- DVS_WIDTH, 346, sensor columns; valid x is 0..DVS_WIDTH-1.
- DVS_HEIGHT, 260, sensor rows; valid y is 0..DVS_HEIGHT-1.
- WORD_SIZE, 18, stored word width: timestamp in the upper bits, polarity in the lower bits.
- CAVIAR_X_Y_BITS, 9, width of each x and y address field.
- READ_LATENCY, 2, cycles from request cycle to valid; legal range 2..4.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cen  in  1  chip enable; a request is issued only when cen=1.
- rw  in  1  1 = write via port 1; 0 = read on both ports.
- addr_port1_x  in  CAVIAR_X_Y_BITS  port 1 column.
- addr_port1_y  in  CAVIAR_X_Y_BITS  port 1 row.
- addr_port2_x  in  CAVIAR_X_Y_BITS  port 2 column.
- addr_port2_y  in  CAVIAR_X_Y_BITS  port 2 row.
- write_data_mem  in  WORD_SIZE  write word, stored verbatim.
- read_data1_mem  out  WORD_SIZE  port 1 read data.
- read_data2_mem  out  WORD_SIZE  port 2 read data.
- read_data_mem_vld1  out  1  port 1 data valid, one-cycle pulse per read.
- read_data_mem_vld2  out  1  port 2 data valid, one-cycle pulse per read.
- init_done  out  1  high once the clear sweep finishes.
- oob_wr_err  out  1  sticky; a write was attempted at an out-of-range address.

Behaviour:
- Reset (async, rst=1):
  - All outputs go to 0 and the pipeline is flushed.
  - The FSM enters CLEAR. Asserting reset mid-sweep or mid-read restarts from CLEAR; in-flight reads are discarded with no vld.
- Addressing:
  - lin = y*DVS_WIDTH + x, width clog2(DVS_WIDTH*DVS_HEIGHT) (17 bits at defaults).
  - A port is in range iff x<DVS_WIDTH and y<DVS_HEIGHT. The range check is on raw fields before multiplication, so lin never wraps.
- FSM states:
  - CLEAR:
    - Clear counter k runs 0..ceil(N/2)-1, where N = DVS_WIDTH*DVS_HEIGHT.
    - Each cycle writes 0 to entries 2k and 2k+1; the entry 2k+1 write is suppressed when 2k+1 >= N.
    - The sweep takes 44980 cycles at defaults.
    - cen/rw are ignored; no vld is produced and no write is performed.
    - After the last pair, go to READY and set init_done=1 on the next edge.
  - READY:
    - Requests are accepted every cycle with no back-pressure. The initiator stalls by waiting on vld.
    - Leaves READY only on reset.
- Read (cen=1, rw=0, in READY):
  - Both ports are read.
  - Request in cycle t gives vld1 and vld2 high together in cycle t+READ_LATENCY, with data.
  - An out-of-range port still returns vld=1 with data 0, and its array read is suppressed.
  - Back-to-back reads are fully pipelined: one result pair per cycle.
- Write (cen=1, rw=1, in READY):
  - write_data_mem is written to the port 1 address at the edge ending cycle t. Port 2 is ignored.
  - No vld results from a write cycle.
  - Out-of-range write: dropped, and oob_wr_err is set to 1 (cleared only by reset).
- Hazard: a read issued at cycle t+1 or later to an address written at cycle t returns the new word; no stale data.
- cen=0: no operation. Data outputs hold their last value; vld outputs are 0.
- Both ports at the same address: both return the same word.

Optional Feature:
- TS_MEM_PARITY_EN defined:
  - Each entry stores one extra even-parity bit over the word, computed on write.
  - Clear writes parity 0.
  - Each read recomputes parity. A mismatch on an in-range port sets the sticky output parity_err (1 bit, reset 0).
  - Read data and vld are unaffected by a mismatch.
- Not defined: no parity storage, and the parity_err port is absent.

Test Plan:
- Reset, then idle -> init_done=0 for exactly 44980 cycles after rst falls, then 1. Any read before that gives no vld pulses.
- Post-init, read (x=5,y=7) and (x=345,y=259) -> vld1=vld2=1 two cycles later, both data 0.
- Write 0x1ABCD to (10,20) at cycle t; read (10,20) on both ports at t+1 -> read_data1=read_data2=0x1ABCD at t+3.
- Read port1 (346,0), port2 (0,260) -> both vld=1 with data 0. Write to (400,3) -> oob_wr_err=1; a read of (400 mod 512 alias, 3) does not show the written word.
- 25 back-to-back reads with cen held -> 25 consecutive vld pulse pairs, none dropped or duplicated. Toggle cen low for 3 cycles mid-stream -> 3-cycle gap in vld.
- Assert rst mid-burst with 2 reads in flight -> no vld afterwards, init_done=0. A previously written entry reads 0 after the sweep completes.
